fic0_apb_arbiter: RTL and testbench

- Two-requester arbiter and APB3 master sequencer in front of the MSS FIC_0 APB slave port (FIC_0_APB_S_*).
- Lets two fabric engines (NAND command engine on port 0, debug/config engine on port 1) share the single fabric-to-MSS APB path.
- Each requester uses a simple level REQ / pulse DONE handshake. The block runs the APB SETUP/ACCESS phases, applies round-robin arbitration and an optional PREADY timeout.

---
 rtl/fic0_apb_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_fic0_apb_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fic0_apb_arbiter.sv
// Two-port round-robin arbiter and APB3 master sequencer for the MSS FIC_0 APB slave path.
// Each port uses a level REQ / pulse DONE handshake; an optional PREADY timeout aborts stuck transfers.
module fic0_apb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_WIDTH       = 9
) (
  input  logic        FIC_0_CLK,
  input  logic        FAB_RESET,
  input  logic        R0_REQ,
  input  logic        R0_WRITE,
  input  logic [31:0] R0_ADDR,
  input  logic [31:0] R0_WDATA,
  output logic        R0_DONE,
  output logic [31:0] R0_RDATA,
  output logic        R0_ERR,
  input  logic        R1_REQ,
  input  logic        R1_WRITE,
  input  logic [31:0] R1_ADDR,
  input  logic [31:0] R1_WDATA,
  output logic        R1_DONE,
  output logic [31:0] R1_RDATA,
  output logic        R1_ERR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic        BUSY,
  output logic        OWNER
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETUP    = 2'd1;
  localparam logic [1:0] ST_ACCESS   = 2'd2;
  localparam logic [1:0] ST_COMPLETE = 2'd3;

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);
  localparam bit                  TO_EN    = (TIMEOUT_CYCLES != 0);

  logic [1:0]          state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic                write_q, write_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]         rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic                busy_q, busy_d;

  logic                gnt_s;
  logic [TO_WIDTH-1:0] cnt_inc_s;
  logic                timeout_s;
  logic [31:0]         cap_rdata_s;
  logic                cap_err_s;

  // On contention the port that was not served last wins.
  assign gnt_s       = (R0_REQ && R1_REQ) ? ~last_q : R1_REQ;
  assign cnt_inc_s   = cnt_q + TO_WIDTH'(1);
  assign timeout_s   = TO_EN && !PREADY && (cnt_inc_s == TO_LIMIT);
  assign cap_rdata_s = (PREADY && !write_q) ? PRDATA : 32'h0000_0000;
  assign cap_err_s   = PREADY ? PSLVERR : 1'b1;

  // Next-state and datapath logic for the APB sequencer.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    cnt_d     = cnt_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    err0_d    = err0_q;
    err1_d    = err1_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (R0_REQ || R1_REQ) begin
          state_d = ST_SETUP;
          owner_d = gnt_s;
          last_d  = gnt_s;
          write_d = gnt_s ? R1_WRITE : R0_WRITE;
          addr_d  = (gnt_s ? R1_ADDR : R0_ADDR) & 32'hFFFF_FFFC;
          wdata_d = gnt_s ? R1_WDATA : R0_WDATA;
          psel_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        cnt_d     = {TO_WIDTH{1'b0}};
      end
      ST_ACCESS: begin
        // PREADY takes priority over a coincident timeout through cap_rdata_s/cap_err_s.
        if (PREADY || timeout_s) begin
          state_d   = ST_COMPLETE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (owner_q) begin
            done1_d  = 1'b1;
            rdata1_d = cap_rdata_s;
            err1_d   = cap_err_s;
          end else begin
            done0_d  = 1'b1;
            rdata0_d = cap_rdata_s;
            err0_d   = cap_err_s;
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_COMPLETE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset kills any transfer in flight.
  always_ff @(posedge FIC_0_CLK or posedge FAB_RESET) begin
    if (FAB_RESET) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      cnt_q     <= {TO_WIDTH{1'b0}};
      rdata0_q  <= 32'h0000_0000;
      rdata1_q  <= 32'h0000_0000;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      cnt_q     <= cnt_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      busy_q    <= busy_d;
    end
  end

  assign PSEL     = psel_q;
  assign PENABLE  = penable_q;
  assign PWRITE   = write_q;
  assign PADDR    = addr_q;
  assign PWDATA   = wdata_q;
  assign R0_DONE  = done0_q;
  assign R0_RDATA = rdata0_q;
  assign R0_ERR   = err0_q;
  assign R1_DONE  = done1_q;
  assign R1_RDATA = rdata1_q;
  assign R1_ERR   = err1_q;
  assign BUSY     = busy_q;
  assign OWNER    = owner_q;

endmodule

// File: tb/tb_fic0_apb_arbiter.sv
// Bench for fic0_apb_arbiter: directed scenarios plus randomized traffic against a rule-level model.
// Two instances share inputs: one with the default timeout, one with a 4-cycle timeout.
module tb_fic0_apb_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req, wr;
  logic [31:0] addr [2];
  logic [31:0] wdat [2];
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        use_to;

  logic        a_done0, a_done1, a_err0, a_err1, a_psel, a_pen, a_pwr, a_busy, a_own;
  logic        b_done0, b_done1, b_err0, b_err1, b_psel, b_pen, b_pwr, b_busy, b_own;
  logic [31:0] a_rd0, a_rd1, a_paddr, a_pwdata, b_rd0, b_rd1, b_paddr, b_pwdata;

  fic0_apb_arbiter dut (
    .FIC_0_CLK(clk), .FAB_RESET(rst),
    .R0_REQ(req[0]), .R0_WRITE(wr[0]), .R0_ADDR(addr[0]), .R0_WDATA(wdat[0]),
    .R0_DONE(a_done0), .R0_RDATA(a_rd0), .R0_ERR(a_err0),
    .R1_REQ(req[1]), .R1_WRITE(wr[1]), .R1_ADDR(addr[1]), .R1_WDATA(wdat[1]),
    .R1_DONE(a_done1), .R1_RDATA(a_rd1), .R1_ERR(a_err1),
    .PSEL(a_psel), .PENABLE(a_pen), .PWRITE(a_pwr), .PADDR(a_paddr), .PWDATA(a_pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr), .BUSY(a_busy), .OWNER(a_own)
  );

  fic0_apb_arbiter #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(9)) dut_to (
    .FIC_0_CLK(clk), .FAB_RESET(rst),
    .R0_REQ(req[0]), .R0_WRITE(wr[0]), .R0_ADDR(addr[0]), .R0_WDATA(wdat[0]),
    .R0_DONE(b_done0), .R0_RDATA(b_rd0), .R0_ERR(b_err0),
    .R1_REQ(req[1]), .R1_WRITE(wr[1]), .R1_ADDR(addr[1]), .R1_WDATA(wdat[1]),
    .R1_DONE(b_done1), .R1_RDATA(b_rd1), .R1_ERR(b_err1),
    .PSEL(b_psel), .PENABLE(b_pen), .PWRITE(b_pwr), .PADDR(b_paddr), .PWDATA(b_pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr), .BUSY(b_busy), .OWNER(b_own)
  );

  logic [1:0]  o_done, o_err;
  logic [31:0] o_rd0, o_rd1, o_paddr, o_pwdata;
  logic        o_psel, o_pen, o_pwr, o_busy, o_own;
  assign o_done   = use_to ? {b_done1, b_done0} : {a_done1, a_done0};
  assign o_err    = use_to ? {b_err1, b_err0} : {a_err1, a_err0};
  assign o_rd0    = use_to ? b_rd0 : a_rd0;
  assign o_rd1    = use_to ? b_rd1 : a_rd1;
  assign o_paddr  = use_to ? b_paddr : a_paddr;
  assign o_pwdata = use_to ? b_pwdata : a_pwdata;
  assign o_psel   = use_to ? b_psel : a_psel;
  assign o_pen    = use_to ? b_pen : a_pen;
  assign o_pwr    = use_to ? b_pwr : a_pwr;
  assign o_busy   = use_to ? b_busy : a_busy;
  assign o_own    = use_to ? b_own : a_own;

  int checks = 0;
  int failures = 0;

  // Observations gathered by run_xfer for the test tasks to judge.
  logic        ob_hung, ob_stable, ob_pen_bad, ob_pen_setup, ob_owner, ob_pwrite, ob_busy;
  logic        ob_psel_done;
  logic [1:0]  ob_done, ob_err;
  logic [31:0] ob_paddr, ob_pwdata, ob_rd0, ob_rd1;
  int          ob_wait, ob_lat, ob_psel_cycles;

  function automatic int exp_acc(input int waits, input int t);
    return (t != 0 && waits >= t) ? t : waits + 1;
  endfunction

  task automatic apply_reset(input logic to);
    use_to = to; rst = 1'b1; req = 2'b00; pready = 1'b0; pslverr = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic new_payload(input int p);
    req[p] = 1'b1; wr[p] = 1'($urandom_range(0, 1)); addr[p] = $urandom(); wdat[p] = $urandom();
  endtask

  // Acts as APB slave for one transfer: PREADY low for 'waits' ACCESS cycles, then high.
  task automatic run_xfer(input int waits, input logic [31:0] rd, input logic serr, input bit drop);
    int n;
    int k;
    ob_hung = 1'b0; ob_stable = 1'b1; ob_pen_bad = 1'b0; ob_psel_cycles = 0; ob_lat = 0;
    ob_done = 2'b00; pready = 1'b0; pslverr = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_psel && n < 20);
    ob_wait = n;
    if (!o_psel) begin ob_hung = 1'b1; return; end
    ob_pen_setup = o_pen; ob_owner = o_own; ob_paddr = o_paddr; ob_pwrite = o_pwr;
    ob_pwdata = o_pwdata; ob_busy = o_busy; ob_psel_cycles = 1;
    k = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); ob_lat++;
      if (o_done != 2'b00) break;
      if (o_psel) begin
        ob_psel_cycles++;
        if (!o_pen) ob_pen_bad = 1'b1;
        if (o_paddr !== ob_paddr || o_pwdata !== ob_pwdata || o_pwr !== ob_pwrite) ob_stable = 1'b0;
        pready  = (k >= waits);
        prdata  = (k >= waits) ? rd : $urandom();
        pslverr = (k >= waits) ? serr : 1'b0;
        k++;
      end else if (o_pen) begin
        ob_pen_bad = 1'b1;
      end
    end
    if (o_done == 2'b00) begin ob_hung = 1'b1; return; end
    ob_done = o_done; ob_rd0 = o_rd0; ob_rd1 = o_rd1; ob_err = o_err; ob_psel_done = o_psel;
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom();
    if (drop) req = req & ~o_done;
  endtask

  task automatic test_reset();
    rst = 1'b1; use_to = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if ({o_psel, o_pen, o_pwr, o_busy, o_own, o_done, o_err} !== 9'h000) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 0", {o_psel, o_pen, o_pwr, o_busy, o_own, o_done, o_err}); end
    checks++; if ({o_paddr, o_pwdata, o_rd0, o_rd1} !== 128'h0) begin
      failures++; $display("FAIL reset_data: got %h expected 0", {o_paddr, o_pwdata, o_rd0, o_rd1}); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    apply_reset(1'b0);
    wr[0] = 1'b0; addr[0] = 32'h4000_0013; wdat[0] = $urandom(); req = 2'b01;
    run_xfer(0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    checks++; if (ob_hung !== 1'b0) begin failures++; $display("FAIL rd_hang: got %b expected 0", ob_hung); end
    checks++; if (ob_wait !== 1) begin failures++; $display("FAIL rd_setup_lat: got %0d expected 1", ob_wait); end
    checks++; if (ob_paddr !== 32'h4000_0010) begin failures++; $display("FAIL rd_paddr: got %h expected 40000010", ob_paddr); end
    checks++; if ({ob_pen_setup, ob_pwrite, ob_busy} !== 3'b001) begin
      failures++; $display("FAIL rd_setup_ctl: got %b expected 001", {ob_pen_setup, ob_pwrite, ob_busy}); end
    checks++; if (ob_psel_cycles !== 2) begin failures++; $display("FAIL rd_psel_len: got %0d expected 2", ob_psel_cycles); end
    checks++; if (ob_lat !== 2) begin failures++; $display("FAIL rd_done_lat: got %0d expected 2", ob_lat); end
    checks++; if (ob_done !== 2'b01) begin failures++; $display("FAIL rd_done: got %b expected 01", ob_done); end
    checks++; if ({ob_rd0, ob_err, ob_psel_done} !== {32'hDEAD_BEEF, 2'b00, 1'b0}) begin
      failures++; $display("FAIL rd_result: got %h/%b/%b expected deadbeef/00/0", ob_rd0, ob_err, ob_psel_done); end
  endtask

  task automatic test_wait_states();
    wr[1] = 1'b1; addr[1] = $urandom(); wdat[1] = 32'h1234_5678; req = 2'b10;
    run_xfer(5, $urandom(), 1'b0, 1'b1);
    checks++; if (ob_hung !== 1'b0) begin failures++; $display("FAIL ws_hang: got %b expected 0", ob_hung); end
    checks++; if ({ob_stable, ob_pen_bad} !== 2'b10) begin
      failures++; $display("FAIL ws_stable: got %b expected 10", {ob_stable, ob_pen_bad}); end
    checks++; if (ob_psel_cycles !== 7) begin failures++; $display("FAIL ws_psel_len: got %0d expected 7", ob_psel_cycles); end
    checks++; if (ob_lat !== 7) begin failures++; $display("FAIL ws_done_lat: got %0d expected 7", ob_lat); end
    checks++; if (ob_done !== 2'b10) begin failures++; $display("FAIL ws_done: got %b expected 10", ob_done); end
    checks++; if ({ob_pwdata, ob_pwrite, ob_paddr} !== {32'h1234_5678, 1'b1, addr[1] & 32'hFFFF_FFFC}) begin
      failures++; $display("FAIL ws_apb: got %h/%b/%h", ob_pwdata, ob_pwrite, ob_paddr); end
    checks++; if ({ob_rd1, ob_err, ob_rd0} !== {32'h0, 2'b00, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL ws_result: got %h/%b/%h expected 0/00/deadbeef", ob_rd1, ob_err, ob_rd0); end
  endtask

  task automatic test_contention();
    logic       last;
    logic       g;
    logic [31:0] rd;
    apply_reset(1'b0);
    wr = 2'b00; addr[0] = 32'h1000_0004; addr[1] = 32'h2000_0008; req = 2'b11;
    last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g = ~last; last = g; rd = $urandom();
      run_xfer(0, rd, 1'b0, 1'b0);
      checks++; if ({ob_hung, ob_owner, ob_done} !== {1'b0, g, (g ? 2'b10 : 2'b01)}) begin
        failures++; $display("FAIL cont_grant%0d: got hung=%b own=%b done=%b expected own=%b", i, ob_hung, ob_owner, ob_done, g); end
      checks++; if (ob_paddr !== addr[g]) begin failures++; $display("FAIL cont_paddr%0d: got %h expected %h", i, ob_paddr, addr[g]); end
      checks++; if ((g ? ob_rd1 : ob_rd0) !== rd) begin
        failures++; $display("FAIL cont_rdata%0d: got %h expected %h", i, (g ? ob_rd1 : ob_rd0), rd); end
    end
    req = 2'b00;
    @(negedge clk); @(negedge clk);
    checks++; if ({o_busy, o_psel} !== 2'b00) begin failures++; $display("FAIL cont_idle: got %b expected 00", {o_busy, o_psel}); end
  endtask

  task automatic test_error_timeout();
    int          waits [3];
    logic [31:0] rds   [3];
    logic        serrs [3];
    bit          timed;
    waits = '{0, 1000, TO - 1};
    rds   = '{32'hA5A5_5A5A, 32'h1111_2222, 32'h0BAD_F00D};
    serrs = '{1'b1, 1'b0, 1'b0};
    apply_reset(1'b1);
    wr[0] = 1'b0; addr[0] = $urandom();
    for (int i = 0; i < 3; i++) begin
      req = 2'b01;
      timed = (waits[i] >= TO);
      run_xfer(waits[i], rds[i], serrs[i], 1'b1);
      checks++; if ({ob_hung, ob_done} !== 3'b001) begin
        failures++; $display("FAIL et_done%0d: got hung=%b done=%b expected 0/01", i, ob_hung, ob_done); end
      checks++; if (ob_psel_cycles !== 1 + exp_acc(waits[i], TO)) begin
        failures++; $display("FAIL et_len%0d: got %0d expected %0d", i, ob_psel_cycles, 1 + exp_acc(waits[i], TO)); end
      checks++; if ({ob_rd0, ob_err[0]} !== {(timed ? 32'h0 : rds[i]), (timed ? 1'b1 : serrs[i])}) begin
        failures++; $display("FAIL et_result%0d: got %h/%b expected %h/%b", i, ob_rd0, ob_err[0],
                             (timed ? 32'h0 : rds[i]), (timed ? 1'b1 : serrs[i])); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [31:0] rd;
    apply_reset(1'b0);
    wr[0] = 1'b0; addr[0] = $urandom(); req = 2'b01;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_pen && n < 10);
    checks++; if ({o_psel, o_pen} !== 2'b11) begin failures++; $display("FAIL rm_access: got %b expected 11", {o_psel, o_pen}); end
    rst = 1'b1;
    #1;
    checks++; if ({o_psel, o_pen, o_busy} !== 3'b000) begin
      failures++; $display("FAIL rm_drop: got %b expected 000", {o_psel, o_pen, o_busy}); end
    @(negedge clk);
    checks++; if (o_done !== 2'b00) begin failures++; $display("FAIL rm_nodone: got %b expected 00", o_done); end
    wr = 2'b00; addr[1] = $urandom(); req = 2'b11; rst = 1'b0;
    rd = $urandom();
    run_xfer(0, rd, 1'b0, 1'b1);
    checks++; if ({ob_hung, ob_owner, ob_done, ob_rd0} !== {1'b0, 1'b0, 2'b01, rd}) begin
      failures++; $display("FAIL rm_first_grant: got own=%b done=%b rd=%h expected 0/01/%h", ob_owner, ob_done, ob_rd0, rd); end
    req = 2'b00;
  endtask

  task automatic test_random();
    logic        last, g, ew, se;
    logic [31:0] ea, ed, rd;
    logic [31:0] exp_rd [2];
    logic        exp_er [2];
    int          waits;
    apply_reset(1'b0);
    last = 1'b1; exp_rd = '{32'h0, 32'h0}; exp_er = '{1'b0, 1'b0};
    for (int it = 0; it < 30; it++) begin
      for (int p = 0; p < 2; p++) if (!req[p] && $urandom_range(0, 1) == 1) new_payload(p);
      if (req == 2'b00) new_payload(int'($urandom_range(0, 1)));
      g = (req == 2'b11) ? ~last : req[1];
      last = g;
      ea = addr[g] & 32'hFFFF_FFFC; ew = wr[g]; ed = wdat[g];
      waits = int'($urandom_range(0, 3)); rd = $urandom(); se = 1'($urandom_range(0, 1));
      run_xfer(waits, rd, se, 1'b1);
      exp_rd[g] = ew ? 32'h0 : rd; exp_er[g] = se;
      checks++; if ({ob_hung, ob_owner, ob_done} !== {1'b0, g, (g ? 2'b10 : 2'b01)}) begin
        failures++; $display("FAIL rnd_grant%0d: got hung=%b own=%b done=%b expected own=%b", it, ob_hung, ob_owner, ob_done, g); end
      checks++; if ({ob_paddr, ob_pwrite, ob_pwdata, ob_stable} !== {ea, ew, ed, 1'b1}) begin
        failures++; $display("FAIL rnd_apb%0d: got %h/%b/%h/%b expected %h/%b/%h/1", it, ob_paddr, ob_pwrite, ob_pwdata, ob_stable, ea, ew, ed); end
      checks++; if ({ob_rd1, ob_rd0, ob_err} !== {exp_rd[1], exp_rd[0], exp_er[1], exp_er[0]}) begin
        failures++; $display("FAIL rnd_result%0d: got %h %h %b expected %h %h %b%b", it, ob_rd1, ob_rd0, ob_err,
                             exp_rd[1], exp_rd[0], exp_er[1], exp_er[0]); end
      checks++; if (ob_psel_cycles !== waits + 2) begin
        failures++; $display("FAIL rnd_len%0d: got %0d expected %0d", it, ob_psel_cycles, waits + 2); end
    end
    req = 2'b00;
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; wr = 2'b00; use_to = 1'b0;
    addr = '{32'h0, 32'h0}; wdat = '{32'h0, 32'h0};
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    test_reset();
    test_single_read();
    test_wait_states();
    test_contention();
    test_error_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
